// File: rtl/enc_scan_if.sv
// Handshake bundle for enc_scan: request vector in, one binary index per beat out.
interface enc_scan_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         onehot;
  logic         zero_err;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, onehot, zero_err
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, onehot, zero_err
  );
endinterface

// File: rtl/enc_scan.sv
// Registered scanning encoder: accepts an N-bit request vector and emits the
// index of each set bit, one per accepted beat, lowest-first or highest-first.
module enc_scan #(
  parameter int N         = 8,
  parameter int W         = $clog2(N),
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  enc_scan_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE_V = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q,     state_d;
  logic [N-1:0] pending_q,   pending_d;
  logic         in_ready_q,  in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q,   out_idx_d;
  logic         out_last_q,  out_last_d;
  logic         onehot_q,    onehot_d;
  logic         zero_err_q,  zero_err_d;

  function automatic logic is_one(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - ONE_V)) == '0);
  endfunction

  // Loop directions make the last match win, giving lowest or highest set bit.
  function automatic logic [W-1:0] pick_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (v[i]) begin
          idx = W'(i);
        end else begin
          idx = idx;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          idx = W'(i);
        end else begin
          idx = idx;
        end
      end
    end
    return idx;
  endfunction

  // Next-state logic; outputs are decoded from the next pending value so
  // their registered copies always match the pending register.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    onehot_d   = onehot_q;
    zero_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          if (bus.in_vec != '0) begin
            pending_d = bus.in_vec;
            onehot_d  = is_one(bus.in_vec);
            state_d   = SCAN;
          end else begin
            zero_err_d = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (out_valid_q && bus.out_ready) begin
          pending_d = pending_q & ~(ONE_V << out_idx_q);
          if (out_last_q) begin
            state_d  = IDLE;
            onehot_d = 1'b0;
          end else begin
            state_d = SCAN;
          end
        end else begin
          pending_d = pending_q;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
        onehot_d  = 1'b0;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == SCAN);
    out_idx_d   = pick_idx(pending_d);
    out_last_d  = (state_d == SCAN) && is_one(pending_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      onehot_q    <= 1'b0;
      zero_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      onehot_q    <= onehot_d;
      zero_err_q  <= zero_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.onehot    = onehot_q;
  assign bus.zero_err  = zero_err_q;

endmodule

// File: tb/tb_enc_scan.sv
// Directed bench: one LSB-first and one MSB-first enc_scan driven in lockstep.
module tb_enc_scan;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       out_ready;
  int         total;
  int         bad;

  enc_scan_if #(.N(8)) if_l ();
  enc_scan_if #(.N(8)) if_h ();

  assign if_l.in_valid  = in_valid;
  assign if_l.in_vec    = in_vec;
  assign if_l.out_ready = out_ready;
  assign if_h.in_valid  = in_valid;
  assign if_h.in_vec    = in_vec;
  assign if_h.out_ready = out_ready;

  enc_scan #(.N(8), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(if_l.slave));
  enc_scan #(.N(8), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst_n(rst_n), .bus(if_h.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_l_rdy"}, 32'(if_l.in_ready), 32'd1);
    chk({tag, "_l_vld"}, 32'(if_l.out_valid), 32'd0);
    chk({tag, "_h_rdy"}, 32'(if_h.in_ready), 32'd1);
    chk({tag, "_h_vld"}, 32'(if_h.out_valid), 32'd0);
  endtask

  // Accept one vector, then drain it; stall=1 drives out_ready 1,0,0,1,0,0,...
  // and pulses in_valid mid-scan, which must not be captured.
  task automatic scan_check(input logic [7:0] vec, input bit stall);
    int exp_l[8];
    int exp_h[8];
    int cnt;
    int k;
    int c;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) begin
        exp_l[cnt] = i;
        cnt++;
      end
    end
    for (int j = 0; j < cnt; j++) exp_h[j] = exp_l[cnt - 1 - j];

    chk("rdy_before", 32'(if_l.in_ready), 32'd1);
    in_valid = 1'b1;
    in_vec   = vec;
    tick();
    in_valid = 1'b0;
    in_vec   = 8'h00;

    k = 0;
    c = 0;
    while (k < cnt && c < 64) begin
      out_ready = stall ? (c % 3 == 0) : 1'b1;
      if (stall && c == 1) begin
        in_valid = 1'b1;
        in_vec   = 8'h01;
      end else begin
        in_valid = 1'b0;
        in_vec   = 8'h00;
      end
      chk("l_vld",  32'(if_l.out_valid), 32'd1);
      chk("l_rdy",  32'(if_l.in_ready),  32'd0);
      chk("l_idx",  32'(if_l.out_idx),   32'(exp_l[k]));
      chk("l_last", 32'(if_l.out_last),  32'(k == cnt - 1));
      chk("l_oh",   32'(if_l.onehot),    32'(cnt == 1));
      chk("h_vld",  32'(if_h.out_valid), 32'd1);
      chk("h_idx",  32'(if_h.out_idx),   32'(exp_h[k]));
      chk("h_last", 32'(if_h.out_last),  32'(k == cnt - 1));
      tick();
      if (out_ready) k++;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("beats", 32'(k), 32'(cnt));
    chk_idle("post");
    chk("oh_clr", 32'(if_l.onehot), 32'd0);
    tick();
    chk_idle("post2");
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_idx",  32'(if_l.out_idx),  32'd0);
    chk("rst_last", 32'(if_l.out_last), 32'd0);
    chk("rst_oh",   32'(if_l.onehot),   32'd0);
    chk("rst_zerr", 32'(if_l.zero_err), 32'd0);
    rst_n = 1'b1;
    tick();

    scan_check(8'b0000_0100, 1'b0);
    scan_check(8'b1010_0110, 1'b0);
    scan_check(8'h80, 1'b0);
    scan_check(8'hFF, 1'b0);

    // Zero vector: one-cycle error pulse, no beat.
    in_valid = 1'b1;
    in_vec   = 8'h00;
    tick();
    in_valid = 1'b0;
    chk("zerr_l", 32'(if_l.zero_err), 32'd1);
    chk("zerr_h", 32'(if_h.zero_err), 32'd1);
    chk_idle("zero");
    tick();
    chk("zerr_off", 32'(if_l.zero_err), 32'd0);
    chk_idle("zero2");

    scan_check(8'hFF, 1'b1);

    // Reset in the middle of a scan drops the remaining beats.
    in_valid = 1'b1;
    in_vec   = 8'b1100_0011;
    tick();
    in_valid = 1'b0;
    chk("mid_idx0", 32'(if_l.out_idx), 32'd0);
    tick();
    chk("mid_idx1", 32'(if_l.out_idx), 32'd1);
    tick();
    chk("mid_vld", 32'(if_l.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_idx", 32'(if_l.out_idx), 32'd0);
    chk("mid_rst_oh",  32'(if_l.onehot),  32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk_idle("after_rst");
    scan_check(8'h10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
